uart_tx_sched: RTL

Round-robin scheduler that shares one UART transmitter among N byte requesters. It accepts one byte at a time from the winning requester and presents it to the transmitter with a single-cycle `DATA_VALID` strobe. It then tracks the transmitter's `BUSY` handshake until the frame finishes, and only then grants the next requester. It sits between the per-channel byte sources and the UART TX top level, on the same `CLK` that runs the UART.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_sched_if.sv | 31 +++
 rtl/uart_tx_sched_rr_arbiter.sv | 42 ++++
 rtl/uart_tx_sched.sv | 111 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART TX scheduler and the UART RX/TX cores.
package uart_pkg;

    // Default payload width of one UART frame.
    localparam int DEFAULT_W = 8;

    // Scheduler FSM encoding.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

    // Parity selection understood by both the RX and the TX cores.
    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2,
        PARITY_MARK = 2'd3
    } parity_t;

    // Number of stop bits the cores use unless configured otherwise.
    localparam int DEFAULT_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester-side and transmitter-side signals of the TX scheduler.
// The master modport is the scheduler; the slave modport is everything around it
// (byte sources and the UART transmitter).
interface uart_tx_sched_if
    import uart_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]   REQ_VALID;
    logic [N*W-1:0] REQ_DATA;
    logic [N-1:0]   REQ_READY;
    logic           TX_BUSY;
    logic           TX_DATA_VALID;
    logic [W-1:0]   P_DATA;
    logic [IW-1:0]  GRANT_ID;
    logic           TO_ERR;

    modport master (
        input  REQ_VALID, REQ_DATA, TX_BUSY,
        output REQ_READY, TX_DATA_VALID, P_DATA, GRANT_ID, TO_ERR
    );

    modport slave (
        output REQ_VALID, REQ_DATA, TX_BUSY,
        input  REQ_READY, TX_DATA_VALID, P_DATA, GRANT_ID, TO_ERR
    );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: stateless round-robin pick. Returns the first requester at or after
// ptr (wrapping modulo N) as a one-hot grant and as an index. The pointer itself
// is owned by the caller.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] rot;
    logic         found;
    int           k;

    // Scan N positions starting at ptr; the first valid one wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        rot   = '0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            rot = req_valid >> k;
            if (!found && rot[0]) begin
                found = 1'b1;
                gnt   = N'(1) << k;
                idx   = IW'(k);
            end
        end
    end

    assign any = |req_valid;

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter among N byte requesters.
// One byte is granted round-robin, strobed to the transmitter, and the next
// grant waits until the transmitter's BUSY handshake has completed (or timed out).
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input logic              CLK,
    input logic              RST,
    uart_tx_sched_if.master  bus
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    sched_state_t  state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [N-1:0]  req_ready;
    logic          tx_data_valid;
    logic          to_err;
    logic [W-1:0]  p_data;
    logic [IW-1:0] grant_id;

    logic [N-1:0]  arb_gnt;
    logic [IW-1:0] arb_idx;
    logic          arb_any;

    // Pointer after serving requester id, wrapping at N (N need not be a power of two).
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] id);
        if (id == IW'(N - 1)) begin
            return '0;
        end
        return id + IW'(1);
    endfunction

    rr_arbiter #(.N(N)) u_arb (
        .req_valid (bus.REQ_VALID),
        .ptr       (ptr),
        .gnt       (arb_gnt),
        .idx       (arb_idx),
        .any       (arb_any)
    );

    // Scheduler FSM with registered strobes; grant data is captured only in the grant cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            req_ready     <= '0;
            tx_data_valid <= 1'b0;
            to_err        <= 1'b0;
            p_data        <= '0;
            grant_id      <= '0;
        end else begin
            req_ready     <= '0;
            tx_data_valid <= 1'b0;
            to_err        <= 1'b0;
            case (state)
                IDLE: begin
                    // A transmitter that is still busy blocks any grant.
                    if (!bus.TX_BUSY && arb_any) begin
                        p_data    <= W'(bus.REQ_DATA >> (W * int'(arb_idx)));
                        grant_id  <= arb_idx;
                        req_ready <= arb_gnt;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // BUSY seen here is deliberately ignored; detection starts next state.
                    tx_data_valid <= 1'b1;
                    cnt           <= '0;
                    state         <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.TX_BUSY) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Transmitter never took the byte: drop it and move on.
                        to_err <= 1'b1;
                        ptr    <= next_ptr(grant_id);
                        state  <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.TX_BUSY) begin
                        ptr   <= next_ptr(grant_id);
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.REQ_READY     = req_ready;
    assign bus.TX_DATA_VALID = tx_data_valid;
    assign bus.TO_ERR        = to_err;
    assign bus.P_DATA        = p_data;
    assign bus.GRANT_ID      = grant_id;

endmodule
